// File: rtl/opb_register_bank_simulink2ppc.sv
// OPB slave exposing C_NUM_REGS fabric words as one coherent shadow snapshot,
// plus a CTRL word carrying a 16-bit capture counter and the live-mode enable.
module opb_register_bank_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'hFFFFFFFF,
  parameter logic [31:0] C_HIGHADDR   = 32'h00000000,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex5",
  parameter int unsigned C_NUM_REGS   = 4
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  input  logic [0:31]               OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:31]               OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:31]               Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  input  logic [32*C_NUM_REGS-1:0]  user_data_in,
  input  logic                      user_capture_in
);

  logic [31:0] addr, wdata, offset, word_idx;
  logic        hit, xfer_start, ctrl_wr, capture;
  logic        xfer_ack_q, xfer_ack_d;
  logic [31:0] rdata_q, rdata_d, rd_mux;
  logic        live_q, live_d;
  logic        sw_trig_q, sw_trig_d;
  logic        clr_q, clr_d;
  logic [15:0] count_q, count_d;
  logic [31:0] shadow_q [C_NUM_REGS];
  logic [31:0] shadow_d [C_NUM_REGS];
  logic        unused_ok;

  // Big-endian OPB buses map straight onto [31:0]: bus index 0 is bit 31.
  assign addr     = OPB_ABus;
  assign wdata    = OPB_DBus;
  assign offset   = addr - C_BASEADDR;
  assign word_idx = {2'b00, offset[31:2]};

  assign hit        = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign xfer_start = hit && !xfer_ack_q;
  assign ctrl_wr    = xfer_start && !OPB_RNW && (word_idx == '0) && OPB_BE[3];
  assign capture    = sw_trig_q || user_capture_in;

  always_comb begin
    rd_mux = '0;
    if (word_idx == '0) rd_mux = {count_q, 14'd0, live_q, 1'b0};
    for (int unsigned k = 0; k < C_NUM_REGS; k++) begin
      if (word_idx == k + 1) rd_mux = shadow_q[k];
    end
  end

  always_comb begin
    xfer_ack_d = xfer_start;
    rdata_d    = (xfer_start && OPB_RNW) ? rd_mux : '0;
    sw_trig_d  = ctrl_wr && wdata[0];
    clr_d      = ctrl_wr && wdata[2];
    live_d     = ctrl_wr ? wdata[1] : live_q;
    // Clear and capture landing in the same cycle leave exactly one capture counted.
    count_d = count_q;
    if (clr_q)        count_d = capture ? 16'd1 : 16'd0;
    else if (capture) count_d = count_q + 16'd1;
    for (int unsigned k = 0; k < C_NUM_REGS; k++) begin
      shadow_d[k] = (capture || live_q) ? user_data_in[32*k +: 32] : shadow_q[k];
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      xfer_ack_q <= 1'b0;
      rdata_q    <= '0;
      live_q     <= 1'b0;
      sw_trig_q  <= 1'b0;
      clr_q      <= 1'b0;
      count_q    <= '0;
      shadow_q   <= '{default: '0};
    end else begin
      xfer_ack_q <= xfer_ack_d;
      rdata_q    <= rdata_d;
      live_q     <= live_d;
      sw_trig_q  <= sw_trig_d;
      clr_q      <= clr_d;
      count_q    <= count_d;
      shadow_q   <= shadow_d;
    end
  end

  assign Sl_DBus    = rdata_q;
  assign Sl_xferAck = xfer_ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2], wdata[31:3], offset[1:0],
                       C_FAMILY, C_OPB_AWIDTH, C_OPB_DWIDTH};

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Scoreboard bench: driver pushes expected per-cycle bus responses, a monitor
// compares them on the falling edge against a transaction-level register model.
module tb_opb_register_bank_simulink2ppc;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] HIGH = 32'h0001_00FF;
  localparam int unsigned NREG = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [0:31]        abus, dbus, sl_dbus;
  logic [0:3]         be;
  logic               rnw, sel, seq;
  logic               ack, err, retry, tout;
  logic [32*NREG-1:0] udata;
  logic               ucap;

  opb_register_bank_simulink2ppc #(
    .C_BASEADDR  (BASE),
    .C_HIGHADDR  (HIGH),
    .C_OPB_AWIDTH(32),
    .C_OPB_DWIDTH(32),
    .C_FAMILY    ("virtex5"),
    .C_NUM_REGS  (NREG)
  ) dut (
    .OPB_Clk        (clk),
    .OPB_Rst_n      (rst_n),
    .OPB_ABus       (abus),
    .OPB_BE         (be),
    .OPB_DBus       (dbus),
    .OPB_RNW        (rnw),
    .OPB_select     (sel),
    .OPB_seqAddr    (seq),
    .Sl_DBus        (sl_dbus),
    .Sl_xferAck     (ack),
    .Sl_errAck      (err),
    .Sl_retry       (retry),
    .Sl_toutSup     (tout),
    .user_data_in   (udata),
    .user_capture_in(ucap)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    logic        ack;
    logic [31:0] data;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: register contents as software sees them between transactions.
  logic [31:0] m_shadow [NREG];
  logic [15:0] m_count;
  logic        m_live;

  function automatic void push_exp(input int unsigned due, input logic a,
                                   input logic [31:0] d, input string nm);
    exp_t e;
    e.due = due; e.ack = a; e.data = d; e.nm = nm;
    sb.push_back(e);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NREG; k++) m_shadow[k] = '0;
    m_count = '0;
    m_live  = 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int unsigned w;
    if (a < BASE || a > HIGH) return '0;
    w = (a - BASE) >> 2;
    if (w == 0) return {m_count, 14'd0, m_live, 1'b0};
    if (w <= NREG) return m_shadow[w-1];
    return '0;
  endfunction

  function automatic logic [32*NREG-1:0] rand_data();
    logic [32*NREG-1:0] d;
    for (int k = 0; k < NREG; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  always @(negedge clk) begin
    bit   seen;
    exp_t e;
    seen = 1'b0;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      seen = 1'b1;
      checks++;
      if (e.due != cyc || ack !== e.ack || sl_dbus !== e.data || {err, retry, tout} !== 3'b000) begin
        errors++;
        $display("FAIL %s cyc=%0d: got ack=%b dbus=%08h side=%b%b%b, want ack=%b dbus=%08h side=000 (due %0d)",
                 e.nm, cyc, ack, sl_dbus, err, retry, tout, e.ack, e.data, e.due);
      end
    end
    if (!seen && ack !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack cyc=%0d: got ack=%b dbus=%08h, want ack=0", cyc, ack, sl_dbus);
    end
  end

  // One transfer: select for one cycle (T), then one idle cycle. c0/c1 pulse the
  // fabric capture in T / T+1; user data is held for both cycles.
  task automatic do_op(input logic s, input logic r, input logic [31:0] a,
                       input logic [0:3] b, input logic [31:0] wd,
                       input logic c0, input logic c1,
                       input logic [32*NREG-1:0] d, input string nm);
    logic        hit, ctrl_wr, trig, old_live;
    logic [31:0] exp_rd;
    hit    = s && (a >= BASE) && (a <= HIGH);
    exp_rd = (hit && r) ? model_read(a) : '0;
    @(negedge clk);
    udata = d; ucap = c0; sel = s; abus = a; rnw = r; be = b; dbus = wd;
    push_exp(cyc + 1, hit, exp_rd, nm);
    push_exp(cyc + 2, 1'b0, 32'h0, {nm, "_end"});
    @(negedge clk);
    sel = 1'b0; abus = '0; dbus = '0; be = '0; rnw = 1'b0; ucap = c1;
    old_live = m_live;
    ctrl_wr  = hit && !r && ((a - BASE) < 4) && b[3];
    trig     = ctrl_wr && wd[0];
    if (c0) m_count++;
    if (ctrl_wr) m_live = wd[1];
    if (ctrl_wr && wd[2]) m_count = (trig || c1) ? 16'd1 : 16'd0;
    else if (trig || c1)  m_count++;
    if (old_live || m_live || c0 || c1 || trig)
      for (int k = 0; k < NREG; k++) m_shadow[k] = d[32*k +: 32];
  endtask

  task automatic rd(input int unsigned w, input string nm);
    do_op(1'b1, 1'b1, BASE + 4*w, 4'b1111, 32'h0, 1'b0, 1'b0, rand_data(), nm);
  endtask

  task automatic ctrl_wr_op(input logic [31:0] wd, input logic [0:3] b,
                            input logic c0, input logic c1, input string nm);
    do_op(1'b1, 1'b0, BASE, b, wd, c0, c1, udata, nm);
  endtask

  task automatic read_held(input int unsigned w, input string nm);
    logic [31:0] exp_rd;
    exp_rd = model_read(BASE + 4*w);
    @(negedge clk);
    ucap = 1'b0; sel = 1'b1; abus = BASE + 4*w; rnw = 1'b1; be = 4'b1111;
    push_exp(cyc + 1, 1'b1, exp_rd, nm);
    push_exp(cyc + 2, 1'b0, 32'h0, {nm, "_guard"});
    push_exp(cyc + 3, 1'b0, 32'h0, {nm, "_end"});
    @(negedge clk);
    @(negedge clk);
    sel = 1'b0; abus = '0; rnw = 1'b0; be = '0;
    @(negedge clk);
  endtask

  task automatic burst(input int unsigned n, input logic [32*NREG-1:0] d);
    @(negedge clk);
    udata = d; ucap = 1'b1;
    repeat (n) @(negedge clk);
    ucap = 1'b0;
    m_count = m_count + n[15:0];
    for (int k = 0; k < NREG; k++) m_shadow[k] = d[32*k +: 32];
  endtask

  initial begin
    logic [32*NREG-1:0] d;
    logic [31:0]        a;
    int unsigned        kind;

    rst_n = 1'b0; sel = 1'b0; seq = 1'b0; rnw = 1'b0; abus = '0; dbus = '0; be = '0;
    udata = '0; ucap = 1'b0;
    model_reset();

    repeat (3) begin
      @(negedge clk);
      push_exp(cyc + 1, 1'b0, 32'h0, "reset_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;

    rd(0, "rst_ctrl");
    rd(1, "rst_shadow0");
    read_held(0, "held_select");

    for (int k = 0; k < NREG; k++) d[32*k +: 32] = 32'h1000 + k;
    do_op(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 1'b0, d, "fab_cap");
    for (int w = 1; w <= NREG; w++) rd(w, "fab_shadow");
    rd(0, "fab_ctrl");

    udata = rand_data();
    ctrl_wr_op(32'h5, 4'b1111, 1'b1, 1'b1, "clr_trig_wr");
    rd(0, "clr_trig_ctrl");
    rd(1, "clr_trig_shadow");
    ctrl_wr_op(32'h5, 4'b1110, 1'b0, 1'b0, "be_masked_wr");
    rd(0, "be_masked_ctrl");
    ctrl_wr_op(32'h1, 4'b1111, 1'b0, 1'b1, "sw_fab_same_cycle");
    rd(0, "sw_fab_ctrl");

    ctrl_wr_op(32'h2, 4'b1111, 1'b0, 1'b0, "live_on");
    for (int i = 0; i < 5; i++) begin
      d = rand_data();
      d[31:0] = 32'h100 + i;
      do_op(1'b1, 1'b1, BASE + 4, 4'b1111, 32'h0, 1'b0, 1'b0, d, "live_shadow");
    end
    rd(0, "live_ctrl");
    d = rand_data();
    d[31:0] = 32'h200;
    do_op(1'b1, 1'b0, BASE, 4'b1111, 32'h0, 1'b0, 1'b0, d, "live_off");
    for (int i = 0; i < 3; i++) rd(1, "frozen_shadow");

    rd(NREG + 1, "unmapped_read");
    rd(63, "last_word_read");
    do_op(1'b1, 1'b0, BASE + 4, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0, rand_data(), "shadow_write");
    rd(1, "shadow_after_write");
    rd(0, "ctrl_after_shadow_write");
    do_op(1'b1, 1'b1, HIGH + 1, 4'b1111, 32'h0, 1'b0, 1'b0, rand_data(), "above_high");
    do_op(1'b1, 1'b1, BASE - 4, 4'b1111, 32'h0, 1'b0, 1'b0, rand_data(), "below_base");

    do_op(1'b1, 1'b1, BASE + 4, 4'b1111, 32'h0, 1'b1, 1'b0, rand_data(), "collide_old");
    rd(1, "collide_new");

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      d = rand_data();
      case (kind)
        0, 1, 2, 3: begin
          a = BASE + 4 * (($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, NREG + 1));
          do_op(1'b1, 1'b1, a, 4'($urandom), $urandom, ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), d, "rnd_read");
        end
        4, 5: begin
          a = BASE + 4 * $urandom_range(1, 63);
          do_op(1'b1, 1'b0, a, 4'($urandom), $urandom, ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), d, "rnd_write");
        end
        6, 7: do_op(1'b1, 1'b0, BASE, 4'($urandom), $urandom, 1'b0,
                    ($urandom_range(0, 3) == 0), d, "rnd_ctrl_wr");
        8: begin
          a = ($urandom_range(0, 1) == 1) ? BASE - 4 * $urandom_range(1, 8)
                                          : HIGH + 1 + 4 * $urandom_range(0, 8);
          do_op(1'b1, 1'b1, a, 4'b1111, 32'h0, 1'b0, 1'b0, d, "rnd_nohit");
        end
        default: do_op(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, ($urandom_range(0, 1) == 1),
                       1'b0, d, "rnd_idle");
      endcase
    end
    rd(0, "rnd_final_ctrl");

    ctrl_wr_op(32'h4, 4'b1111, 1'b0, 1'b0, "wrap_clear");
    burst(65535, rand_data());
    rd(0, "count_ffff");
    burst(1, rand_data());
    rd(0, "count_wrap");
    rd(2, "wrap_shadow");

    @(negedge clk);
    sel = 1'b1; abus = BASE + 4; rnw = 1'b1; be = 4'b1111; rst_n = 1'b0;
    push_exp(cyc + 1, 1'b0, 32'h0, "rst_t0_noack");
    push_exp(cyc + 2, 1'b0, 32'h0, "rst_t0_end");
    @(negedge clk);
    sel = 1'b0; abus = '0; rnw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rd(0, "after_rst_ctrl");

    burst(1, rand_data());
    ctrl_wr_op(32'h2, 4'b1111, 1'b0, 1'b0, "pre_async_live");
    @(negedge clk);
    sel = 1'b1; abus = BASE + 4; rnw = 1'b1; be = 4'b1111;
    push_exp(cyc + 1, 1'b0, 32'h0, "async_rst_ack");
    @(posedge clk);
    #1;
    rst_n = 1'b0; sel = 1'b0; abus = '0; rnw = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rd(0, "async_rst_ctrl");
    rd(1, "async_rst_shadow");

    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opb_register_bank_simulink2ppc.md
# opb_register_bank_simulink2ppc

Multi-channel successor to the single-register Simulink-to-PPC OPB slave. It captures `C_NUM_REGS` 32-bit fabric words into shadow registers as one coherent snapshot and exposes them to the PowerPC over OPB. A snapshot is taken on a software trigger, a fabric trigger, or continuously in live mode, and a capture counter is readable by software. The block sits on the OPB bus beside the existing snap and 10GbE control registers. All fabric inputs are synchronous to `OPB_Clk`.

## Interface
Parameters:
- `C_BASEADDR`, 32'hFFFFFFFF: first byte address of the region; aligned to its size.
- `C_HIGHADDR`, 32'h00000000: last byte address; region ≥ 4*(C_NUM_REGS+1) bytes.
- `C_OPB_AWIDTH`, 32: OPB address width.
- `C_OPB_DWIDTH`, 32: OPB data width; only 32 supported.
- `C_FAMILY`, "virtex5": target family.
- `C_NUM_REGS`, 4: channel count, legal range 1..63.

Ports:
- `OPB_Clk` in 1: the only clock; every register is clocked by it.
- `OPB_Rst_n` in 1: reset, asynchronous assert, active-low, synchronously released upstream.
- `OPB_ABus` in [0:31]: address.
- `OPB_BE` in [0:3]: byte enables; BE[0] covers DBus[0:7].
- `OPB_DBus` in [0:31]: write data.
- `OPB_RNW` in 1: 1 = read.
- `OPB_select` in 1: transfer in progress.
- `OPB_seqAddr` in 1: ignored.
- `Sl_DBus` out [0:31]: read data; zero when not acking a read.
- `Sl_xferAck` out 1: one-cycle transfer acknowledge.
- `Sl_errAck`, `Sl_retry`, `Sl_toutSup` out 1 each: tied 0.
- `user_data_in` in [32*C_NUM_REGS-1:0]: channel k is bits [32k+31:32k].
- `user_capture_in` in 1: fabric capture strobe, one per high cycle.

## Operation
- Bit numbering: "bit n" means DBus[31-n].
- Hit: `OPB_select`=1 and C_BASEADDR ≤ ABus ≤ C_HIGHADDR. Word index w = (ABus − C_BASEADDR)>>2.
- Map:
  - w=0 is CTRL.
  - w=1..C_NUM_REGS is shadow[w−1], read-only.
  - Any other w in the region reads 0, ignores writes, and still acks.
- CTRL read: bits[31:16] = capture_count, bit1 = live, all other bits 0.
- CTRL write: only byte 0 (bits 7:0) is honoured, and only when BE[3]=1.
  - bit0 = 1: software trigger.
  - bit1: sets live.
  - bit2 = 1: clear capture_count.
  - Other bytes are ignored.
- Capture event: software trigger OR `user_capture_in`.
  - All shadows load `user_data_in` in the same cycle.
  - capture_count increments by 1 (16-bit, wraps 0xFFFF→0x0000).
  - Simultaneous software and fabric triggers count once.
- Live mode (live=1): shadows load every cycle and count does not increment. Triggers in live mode still increment the count.
- Clear and trigger in the same write: count = 1 afterwards.
- Clear and fabric trigger in the same cycle: count = 1.
- Writes to shadow registers: data discarded, ack issued.
- Reset (any cycle, including mid-transfer):
  - Shadows, capture_count, live, `Sl_DBus`, `Sl_xferAck` all go to 0 immediately.
  - A transfer in flight is not acked; the master times out or retries.

## Timing
- Transfer with hit asserted at cycle T: `Sl_xferAck`=1 at T+1 for exactly one cycle.
- `Sl_DBus` holds read data at T+1 only, zero otherwise.
- Ack guard: no new ack while `Sl_xferAck`=1. A select still high at T+1 does not re-ack; back-to-back transfers ack at most every second cycle.
- Read data is the register value at cycle T. A capture at T updates the shadows at T+1, so that read returns the pre-capture value.
- CTRL write takes effect at T+1:
  - A software trigger at T captures `user_data_in` sampled at T+1.
  - The count is visible to a read issued at T+2 or later.
- Fabric trigger: `user_capture_in` high at T captures `user_data_in` of cycle T; shadow and count are updated at T+1.
- Live mode: a shadow lags `user_data_in` by 1 cycle.
- Non-hit select: no ack, `Sl_DBus`=0.

## Test plan
- Reset: hold `OPB_Rst_n`=0 → all outputs 0. Release; read CTRL → 0x00000000; read shadow[0] → 0.
- Fabric capture: C_NUM_REGS=4, channel k = 0x1000+k, pulse `user_capture_in`, then change inputs. Reads of w=1..4 → 0x1000..0x1003; CTRL → 0x00010000. Each ack lasts one cycle.
- Simultaneous clear + trigger: CTRL write 0x00000005 with BE=1111 while `user_capture_in`=1 → CTRL reads 0x00010000.
- Same write with BE=1110 → no trigger and no clear.
- Live mode: write CTRL=0x2 and drive a counter on channel 0 → successive reads of w=1 increase and count stays unchanged. Write 0x0 → value frozen.
- Wrap and boundaries:
  - 65536 fabric triggers → count 0x0000.
  - Read w=C_NUM_REGS+1 → 0 with ack.
  - Write to w=1 → shadow unchanged.
  - Address just above C_HIGHADDR → no ack.
- Read/capture collision: `user_capture_in` high in the same cycle as a read select on w=1 → read returns the old value; the next read returns the new value.
- Reset asserted at T+0 of a read → no ack.
